// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan driver: active-low glyph patterns
// (bit order GFEDCBA) and glyph-set selectors.
package seg_pkg;

    localparam int GLYPH_HEX  = 0;
    localparam int GLYPH_GAME = 1;

    localparam logic [6:0] SEG_0   = 7'b1000000;
    localparam logic [6:0] SEG_1   = 7'b1111001;
    localparam logic [6:0] SEG_2   = 7'b0100100;
    localparam logic [6:0] SEG_3   = 7'b0110000;
    localparam logic [6:0] SEG_4   = 7'b0011001;
    localparam logic [6:0] SEG_5   = 7'b0010010;
    localparam logic [6:0] SEG_6   = 7'b0000010;
    localparam logic [6:0] SEG_7   = 7'b1111000;
    localparam logic [6:0] SEG_8   = 7'b0000000;
    localparam logic [6:0] SEG_9   = 7'b0010000;

    localparam logic [6:0] SEG_A   = 7'b0001000;
    localparam logic [6:0] SEG_B   = 7'b0000011;
    localparam logic [6:0] SEG_C   = 7'b1000110;
    localparam logic [6:0] SEG_D   = 7'b0100001;
    localparam logic [6:0] SEG_E   = 7'b0000110;
    localparam logic [6:0] SEG_F   = 7'b0001110;

    localparam logic [6:0] SEG_T   = 7'b0000111;
    localparam logic [6:0] SEG_R   = 7'b0101111;
    localparam logic [6:0] SEG_Y   = 7'b0010001;
    localparam logic [6:0] SEG_L   = 7'b1000111;

    localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Host-side bundle of the scan driver: per-digit data, load strobe and the
// board-facing display pins.
interface seg_scan_driver_if #(
    parameter int N_DIGITS = 4
);

    logic [4*N_DIGITS-1:0] digits_in;
    logic [N_DIGITS-1:0]   blank_in;
    logic [N_DIGITS-1:0]   blink_in;
    logic [N_DIGITS-1:0]   dp_in;
    logic                  load;
    logic                  load_ack;
    logic [6:0]            seg;
    logic                  dp;
    logic [N_DIGITS-1:0]   an;
    logic                  frame_pulse;

    // load is a one-cycle strobe with no back-pressure: data is always taken
    // into the shadow copy; load_ack pulses when that copy reaches the display.
    modport master (
        output digits_in, blank_in, blink_in, dp_in, load,
        input  load_ack, seg, dp, an, frame_pulse
    );

    modport slave (
        input  digits_in, blank_in, blink_in, dp_in, load,
        output load_ack, seg, dp, an, frame_pulse
    );

endinterface

// File: rtl/seg_glyph_decode.sv
// Combinational nibble-to-segment decoder; letters above 9 come from either
// the hex set or the game set (t r y L E blank).
module seg_glyph_decode
    import seg_pkg::*;
#(
    parameter int GLYPH_MODE = GLYPH_GAME
) (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    localparam bit HEX = (GLYPH_MODE == GLYPH_HEX);

    always_comb begin
        seg = SEG_OFF;
        case (nib)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = HEX ? SEG_A : SEG_T;
            4'hB: seg = HEX ? SEG_B : SEG_R;
            4'hC: seg = HEX ? SEG_C : SEG_Y;
            4'hD: seg = HEX ? SEG_D : SEG_L;
            4'hE: seg = SEG_E;
            4'hF: seg = HEX ? SEG_F : SEG_OFF;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with tear-free
// shadow/active digit state, blink, blanking and anti-ghost guard time.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int GUARD        = 2,
    parameter int BLINK_FRAMES = 32,
    parameter int GLYPH_MODE   = GLYPH_GAME
) (
    input  logic                  clk,
    input  logic                  rst,
    seg_scan_driver_if.slave      bus
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [PW-1:0]         presc;
    logic [IW-1:0]         idx;
    logic [BW-1:0]         blink_cnt;
    logic                  blink_hidden;
    logic                  pending;

    logic [4*N_DIGITS-1:0] sh_digits, act_digits;
    logic [N_DIGITS-1:0]   sh_blank,  act_blank;
    logic [N_DIGITS-1:0]   sh_blink,  act_blink;
    logic [N_DIGITS-1:0]   sh_dp,     act_dp;

    logic [6:0]            seg_q;
    logic                  dp_q;
    logic [N_DIGITS-1:0]   an_q;
    logic                  load_ack_q;
    logic                  frame_pulse_q;

    logic                  slot_end;
    logic                  boundary;
    logic                  in_guard;
    logic                  dark;
    logic [3:0]            cur_nib;
    logic [6:0]            glyph_seg;
    logic [N_DIGITS-1:0]   an_sel;

    assign slot_end = (presc == PRESC_LAST);
    assign boundary = slot_end && (idx == IDX_LAST);
    assign in_guard = (int'(presc) < GUARD);
    assign cur_nib  = act_digits[4*int'(idx) +: 4];
    assign dark     = act_blank[idx] | (act_blink[idx] & blink_hidden);
    assign an_sel   = ~(N_DIGITS'(1) << idx);

    seg_glyph_decode #(
        .GLYPH_MODE (GLYPH_MODE)
    ) u_glyph (
        .nib (cur_nib),
        .seg (glyph_seg)
    );

    // Scan timing, blink phase and the shadow->active commit at frame wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc         <= '0;
            idx           <= '0;
            blink_cnt     <= '0;
            blink_hidden  <= 1'b0;
            pending       <= 1'b0;
            frame_pulse_q <= 1'b0;
            load_ack_q    <= 1'b0;
            sh_digits     <= '0;
            sh_blank      <= '1;
            sh_blink      <= '0;
            sh_dp         <= '0;
            act_digits    <= '0;
            act_blank     <= '1;
            act_blink     <= '0;
            act_dp        <= '0;
        end else begin
            presc         <= slot_end ? '0 : presc + 1'b1;
            frame_pulse_q <= boundary;
            load_ack_q    <= boundary && pending;

            if (slot_end) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end

            if (boundary) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt    <= '0;
                    blink_hidden <= ~blink_hidden;
                end else begin
                    blink_cnt    <= blink_cnt + 1'b1;
                end
                if (pending) begin
                    act_digits <= sh_digits;
                    act_blank  <= sh_blank;
                    act_blink  <= sh_blink;
                    act_dp     <= sh_dp;
                end
            end

            // A load on a boundary commits the old shadow and keeps the new one pending.
            if (bus.load) begin
                pending   <= 1'b1;
                sh_digits <= bus.digits_in;
                sh_blank  <= bus.blank_in;
                sh_blink  <= bus.blink_in;
                sh_dp     <= bus.dp_in;
            end else if (boundary) begin
                pending   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
            an_q  <= '1;
        end else if (in_guard || dark) begin
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
            an_q  <= '1;
        end else begin
            seg_q <= glyph_seg;
            dp_q  <= ~act_dp[idx];
            an_q  <= an_sel;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.dp          = dp_q;
    assign bus.an          = an_q;
    assign bus.load_ack    = load_ack_q;
    assign bus.frame_pulse = frame_pulse_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: a game-glyph and a hex-glyph instance share the
// same stimulus; per-slot expectations flow through a scoreboard queue.
module tb_seg_scan_driver;
    import seg_pkg::*;

    localparam int N   = 4;
    localparam int DIV = 8;
    localparam int GRD = 2;
    localparam int BF  = 2;
    localparam int W   = 19;
    localparam logic [W-1:0] ALL_OFF = {4'hF, 7'h7F, 7'h7F, 1'b1};

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [15:0] digits;
    logic [3:0]  blank, blink, dpv;
    logic        load;

    seg_scan_driver_if #(.N_DIGITS(N)) if_g ();
    seg_scan_driver_if #(.N_DIGITS(N)) if_h ();

    assign if_g.digits_in = digits;
    assign if_g.blank_in  = blank;
    assign if_g.blink_in  = blink;
    assign if_g.dp_in     = dpv;
    assign if_g.load      = load;
    assign if_h.digits_in = digits;
    assign if_h.blank_in  = blank;
    assign if_h.blink_in  = blink;
    assign if_h.dp_in     = dpv;
    assign if_h.load      = load;

    seg_scan_driver #(.N_DIGITS(N), .SCAN_DIV(DIV), .GUARD(GRD), .BLINK_FRAMES(BF),
                      .GLYPH_MODE(GLYPH_GAME)) dut_g (.clk(clk), .rst(rst), .bus(if_g));
    seg_scan_driver #(.N_DIGITS(N), .SCAN_DIV(DIV), .GUARD(GRD), .BLINK_FRAMES(BF),
                      .GLYPH_MODE(GLYPH_HEX))  dut_h (.clk(clk), .rst(rst), .bus(if_h));

    typedef struct packed {
        logic [15:0]      digits;
        logic [3:0]       blank;
        logic [3:0]       dp;
        logic [3:0][6:0]  seg_g;
        logic [3:0][6:0]  seg_h;
    } vec_t;

    vec_t vecs [7];
    logic [W-1:0] exp_q [$];
    int n_vec = 0;
    int n_mis = 0;
    int frame_cnt = 0;

    always @(negedge clk) begin
        if (rst) frame_cnt <= 0;
        else if (if_g.frame_pulse) frame_cnt <= frame_cnt + 1;
    end

    function automatic logic [6:0] ref_glyph(input bit game, input logic [3:0] nib);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
              7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        if (game) begin
            case (nib)
                4'hA: return 7'b0000111;
                4'hB: return 7'b0101111;
                4'hC: return 7'b0010001;
                4'hD: return 7'b1000111;
                4'hF: return 7'b1111111;
                default: return t[nib];
            endcase
        end
        return t[nib];
    endfunction

    function automatic logic [W-1:0] observed();
        return {if_g.an, if_g.seg, if_h.seg, if_g.dp};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // driver tasks
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulse();
        int n = 0;
        do begin
            step(1);
            n++;
        end while (!if_g.frame_pulse && n < 100);
        if (!if_g.frame_pulse) begin
            n_vec++;
            n_mis++;
            $display("FAIL pulse_timeout: no frame_pulse within %0d cycles", n);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] bl,
                           input logic [3:0] bk, input logic [3:0] dp);
        digits = d;
        blank  = bl;
        blink  = bk;
        dpv    = dp;
        load   = 1'b1;
        step(1);
        load   = 1'b0;
    endtask

    task automatic push_vec(input vec_t v);
        for (int d = 0; d < N; d++) begin
            if (v.blank[d]) exp_q.push_back(ALL_OFF);
            else exp_q.push_back({~(4'b0001 << d), v.seg_g[d], v.seg_h[d], ~v.dp[d]});
        end
    endtask

    // called at the negedge showing frame_pulse; samples guard and lit part of each slot
    task automatic check_frame();
        int k = 0;
        logic [W-1:0] e;
        for (int d = 0; d < N; d++) begin
            step(8 * d + 1 - k);
            k = 8 * d + 1;
            check($sformatf("guard%0d", d), 32'(observed()), 32'(ALL_OFF));
            step(4);
            k += 4;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_mis++;
                $display("FAIL scoreboard_empty slot%0d", d);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("slot%0d", d), 32'(observed()), 32'(e));
            end
        end
    endtask

    // counts cycles to the next frame_pulse while requiring the display dark
    task automatic idle_frame(input string name);
        int cnt = 0;
        int bad = 0;
        do begin
            step(1);
            cnt++;
            if (observed() !== ALL_OFF || if_h.an !== 4'hF || if_h.dp !== 1'b1) bad++;
        end while (!if_g.frame_pulse && cnt < 100);
        check({name, "_period"}, 32'(cnt), 32'(32));
        check({name, "_dark"}, 32'(bad), 32'(0));
        check({name, "_no_ack"}, 32'(if_g.load_ack), 32'(0));
    endtask

    initial begin
        rst = 1'b1;
        digits = '0; blank = '0; blink = '0; dpv = '0; load = 1'b0;

        vecs[0] = '{16'h4321, 4'b0000, 4'b0010,
                    {7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001},
                    {7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001}};
        vecs[1] = '{16'hEDCB, 4'b0000, 4'b0000,
                    {7'b0000110, 7'b1000111, 7'b0010001, 7'b0101111},
                    {7'b0000110, 7'b0100001, 7'b1000110, 7'b0000011}};
        vecs[2] = '{16'hF0A9, 4'b0100, 4'b1001,
                    {7'b1111111, 7'b1000000, 7'b0000111, 7'b0010000},
                    {7'b0001110, 7'b1000000, 7'b0001000, 7'b0010000}};
        vecs[3] = '{16'h7651, 4'b0000, 4'b0000,
                    {7'b1111000, 7'b0000010, 7'b0010010, 7'b1111001},
                    {7'b1111000, 7'b0000010, 7'b0010010, 7'b1111001}};
        for (int i = 4; i < 7; i++) begin
            vecs[i].digits = 16'($urandom);
            vecs[i].blank  = 4'($urandom_range(0, 15));
            vecs[i].dp     = 4'($urandom_range(0, 15));
            for (int d = 0; d < N; d++) begin
                vecs[i].seg_g[d] = ref_glyph(1'b1, vecs[i].digits[4*d +: 4]);
                vecs[i].seg_h[d] = ref_glyph(1'b0, vecs[i].digits[4*d +: 4]);
            end
        end

        step(3);
        check("reset_outputs", 32'(observed()), 32'(ALL_OFF));
        check("reset_pulses", 32'({if_g.load_ack, if_g.frame_pulse}), 32'(0));
        rst = 1'b0;
        idle_frame("idle0");
        idle_frame("idle1");

        // table-driven vectors
        for (int i = 0; i < 7; i++) begin
            step(2);
            do_load(vecs[i].digits, vecs[i].blank, 4'b0000, vecs[i].dp);
            push_vec(vecs[i]);
            wait_pulse();
            check($sformatf("ack_v%0d", i), 32'(if_g.load_ack), 32'(1));
            check_frame();
            wait_pulse();
        end

        // two loads in one frame: the last one wins
        step(2);
        do_load(16'h1111, 4'b0000, 4'b0000, 4'b0000);
        step(7);
        do_load(16'h2222, 4'b0000, 4'b0000, 4'b0000);
        push_vec('{16'h2222, 4'b0000, 4'b0000,
                   {4{7'b0100100}}, {4{7'b0100100}}});
        wait_pulse();
        check("ack_last_wins", 32'(if_g.load_ack), 32'(1));
        check_frame();
        wait_pulse();

        // load sampled on the boundary edge with nothing pending: commit one frame later
        step(31);
        do_load(vecs[3].digits, vecs[3].blank, 4'b0000, vecs[3].dp);
        push_vec(vecs[3]);
        check("bnd_pulse", 32'(if_g.frame_pulse), 32'(1));
        check("bnd_no_ack", 32'(if_g.load_ack), 32'(0));
        wait_pulse();
        check("bnd_late_ack", 32'(if_g.load_ack), 32'(1));
        check_frame();
        wait_pulse();

        // blink on digit 0: visible for two frames, dark for two
        step(2);
        do_load(16'h0008, 4'b0000, 4'b0001, 4'b0000);
        wait_pulse();
        check("ack_blink", 32'(if_g.load_ack), 32'(1));
        for (int f = 0; f < 6; f++) begin
            step(5);
            if (((frame_cnt / 2) % 2) == 0)
                check($sformatf("blink_f%0d", frame_cnt), 32'(observed()),
                      32'({4'b1110, 7'b0000000, 7'b0000000, 1'b1}));
            else
                check($sformatf("blink_f%0d", frame_cnt), 32'(observed()), 32'(ALL_OFF));
            wait_pulse();
        end

        // asynchronous reset in the middle of digit 2's lit time
        step(2);
        do_load(16'h2222, 4'b0000, 4'b0000, 4'b0000);
        wait_pulse();
        step(21);
        check("pre_rst_lit", 32'(if_g.an), 32'(4'b1011));
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_g", 32'({if_g.an, if_g.seg, if_g.dp, if_g.load_ack, if_g.frame_pulse}),
              32'({4'hF, 7'h7F, 1'b1, 1'b0, 1'b0}));
        check("async_rst_h", 32'({if_h.an, if_h.seg, if_h.dp}), 32'({4'hF, 7'h7F, 1'b1}));
        step(2);
        rst = 1'b0;
        idle_frame("post_rst");

        if (exp_q.size() != 0) check("scoreboard_leftover", 32'(exp_q.size()), 32'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
